// File: rtl/pipe_scroller.sv
// ============================================================================
// pipe_scroller: scrolls the 16x16 pipe field, places pipe gaps pseudo-randomly
// and counts pipes passed.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_scroller #(
  parameter int          TICK_DIV     = 12500000,
  parameter int          PIPE_WIDTH   = 2,
  parameter int          PIPE_SPACING = 6,
  parameter int          GAP_SIZE     = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              game_over,
  output logic [15:0][15:0] pipe_out,
  output logic              step,
  output logic              pass,
  output logic [7:0]        score
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = (PIPE_SPACING > 2) ? $clog2(PIPE_SPACING) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] COL_MAX   = CW'(PIPE_SPACING - 1);
  localparam logic [CW-1:0] COL_PW    = CW'(PIPE_WIDTH);
  localparam logic [4:0]    GAP_MOD   = 5'(15 - GAP_SIZE);
  localparam logic [15:0]   LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [CW-1:0]     col_q, col_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [4:0]        gap_q, gap_d;
  logic [15:0][15:0] pipe_q, pipe_d;
  logic              step_q, step_d;
  logic              pass_q, pass_d;
  logic [7:0]        score_q, score_d;

  logic        advance;
  logic        do_step;
  logic [4:0]  gap_sel;
  logic [15:0] new_col;

  // game_over takes priority over a tick wrap in the same cycle
  assign advance = (state_q == S_RUN) && !game_over;
  assign do_step = advance && (tick_q == TICK_MAX);

  always_comb begin
    gap_sel = (col_q == '0) ? (5'd1 + ({1'b0, lfsr_q[3:0]} % GAP_MOD)) : gap_q;
    new_col = '0;
    if (col_q < COL_PW) begin
      for (int r = 0; r < 16; r++) begin
        new_col[r] = !((r >= int'(gap_sel)) && (r < int'(gap_sel) + GAP_SIZE));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    col_d   = col_q;
    lfsr_d  = lfsr_q;
    gap_d   = gap_q;
    pipe_d  = pipe_q;
    step_d  = 1'b0;
    pass_d  = 1'b0;
    score_d = score_q;

    case (state_q)
      S_IDLE: begin
        if (game_over)  state_d = S_HALT;
        else if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (game_over) state_d = S_HALT;
      end
      default: state_d = S_HALT;
    endcase

    if (advance) begin
      tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + 1'b1;
    end

    if (do_step) begin
      pipe_d = {new_col, pipe_q[15:1]};
      step_d = 1'b1;
      gap_d  = gap_sel;
      col_d  = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
      // pass judged on the field as it stood before this shift
      pass_d = (pipe_q[2] != 16'h0000) && (pipe_q[3] == 16'h0000);
      if (pass_d && (score_q != 8'hFF)) score_d = score_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      col_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      gap_q   <= '0;
      pipe_q  <= '0;
      step_q  <= 1'b0;
      pass_q  <= 1'b0;
      score_q <= 8'd0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      col_q   <= col_d;
      lfsr_q  <= lfsr_d;
      gap_q   <= gap_d;
      pipe_q  <= pipe_d;
      step_q  <= step_d;
      pass_q  <= pass_d;
      score_q <= score_d;
    end
  end

  assign pipe_out = pipe_q;
  assign step     = step_q;
  assign pass     = pass_q;
  assign score    = score_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_scroller.sv
// ============================================================================
// tb_pipe_scroller: randomized bench for pipe_scroller against a step-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_scroller;

  localparam int          TD   = 4;
  localparam int          PW   = 2;
  localparam int          PS   = 6;
  localparam int          GS   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic              clk = 1'b0;
  logic              reset, start, game_over;
  logic [15:0][15:0] pipe_out;
  logic              step, pass;
  logic [7:0]        score;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 run, 2 halt; run_cyc counts edges spent running
  int          mode, run_cyc, nsteps, mscore, mgap;
  logic [15:0] mcol [16];
  logic [15:0] mlfsr;
  logic        mstep, mpass;

  always #5 clk = ~clk;

  pipe_scroller #(
    .TICK_DIV(TD), .PIPE_WIDTH(PW), .PIPE_SPACING(PS), .GAP_SIZE(GS), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .game_over(game_over),
    .pipe_out(pipe_out), .step(step), .pass(pass), .score(score)
  );

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] make_col(input int gap);
    logic [15:0] c;
    for (int r = 0; r < 16; r++) c[r] = !((r >= gap) && (r < gap + GS));
    return c;
  endfunction

  // a pipe column: walls at rows 0 and 15, one run of exactly GS open rows
  function automatic bit col_ok(input logic [15:0] c);
    int zeros, runs;
    zeros = 0; runs = 0;
    if (c == 16'h0000) return 1'b1;
    if (!c[0] || !c[15]) return 1'b0;
    for (int r = 1; r < 15; r++) begin
      if (!c[r]) begin
        zeros++;
        if (c[r-1]) runs++;
      end
    end
    return (zeros == GS) && (runs == 1);
  endfunction

  task automatic model_step();
    int k;
    logic [15:0] nc;
    k = nsteps % PS;
    if (k == 0) mgap = 1 + (int'(mlfsr[3:0]) % (15 - GS));
    nc = (k < PW) ? make_col(mgap) : 16'h0000;
    mpass = (mcol[2] != 16'h0000) && (mcol[3] == 16'h0000);
    for (int c = 0; c < 15; c++) mcol[c] = mcol[c+1];
    mcol[15] = nc;
    mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
    nsteps++;
    if (mpass && mscore < 255) mscore++;
    mstep = 1'b1;
  endtask

  task automatic model_edge();
    mstep = 1'b0;
    mpass = 1'b0;
    if (reset) begin
      mode = 0; run_cyc = 0; nsteps = 0; mscore = 0; mgap = 0; mlfsr = SEED;
      for (int c = 0; c < 16; c++) mcol[c] = 16'h0000;
    end else if (mode == 0) begin
      if (game_over) mode = 2;
      else if (start) begin
        mode = 1;
        run_cyc = 0;
      end
    end else if (mode == 1) begin
      if (game_over) mode = 2;
      else begin
        run_cyc++;
        if (run_cyc % TD == 0) model_step();
      end
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic g);
    logic [15:0][15:0] exp;
    reset = r; start = s; game_over = g;
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < 16; c++) exp[c] = mcol[c];
    check("pipe_out", pipe_out, exp);
    check("step", step, mstep);
    check("pass", pass, mpass);
    check("score", score, mscore);
  endtask

  // run until the model reaches target step count, with directed checks on key steps
  task automatic run_to(input int target);
    for (int i = 0; i < 1000 && nsteps < target; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (mstep) begin
        for (int c = 0; c < 16; c++) check("col_shape", col_ok(pipe_out[c]), 1'b1);
        if (nsteps == 1) check("first_col", pipe_out[15], 16'hFFC3);
        if (nsteps == 2) check("second_col", pipe_out[15], 16'hFFC3);
        if (nsteps == 2) check("second_col_14", pipe_out[14], 16'hFFC3);
        if (nsteps == 3) check("third_col", pipe_out[15], 16'h0000);
        if (nsteps == 16) check("pass16", pass, 1'b1);
        if (nsteps == 16) check("score16", score, 8'd1);
        if (nsteps < 16) check("no_early_pass", pass, 1'b0);
      end
    end
    check("run_budget", (nsteps >= target), 1'b1);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; game_over = 1'b0;
    mode = 0; run_cyc = 0; nsteps = 0; mscore = 0; mgap = 0; mlfsr = SEED;
    for (int c = 0; c < 16; c++) mcol[c] = 16'h0000;

    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    n = 20 + $urandom_range(0, 5);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);

    // first run to score 3, then reset mid-run
    cycle(1'b0, 1'b1, 1'b0);
    run_to(30);
    check("score_before_reset", score, 8'd3);
    cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("reset_pipe", pipe_out, 256'h0);
    check("reset_score", score, 8'd0);

    // restart: same first column proves the LFSR reloaded its seed
    cycle(1'b0, 1'b1, 1'b0);
    run_to(3 + $urandom_range(0, 12));

    // game over on the edge where the tick counter would wrap
    for (int i = 0; i < 20 && (run_cyc % TD) != TD - 1; i++) cycle(1'b0, 1'b0, 1'b0);
    check("tick_align", run_cyc % TD, TD - 1);
    cycle(1'b0, 1'b0, 1'b1);
    check("go_no_step", step, 1'b0);
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // start and game_over together in IDLE go straight to HALT
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0);
    check("idle_halt_pipe", pipe_out, 256'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
